// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter with epoch filtering, optional branch priority via WB_ARB_BRANCH_PRIO_EN
package wb_arbiter_pkg;
  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [1:0]  epoch;
    logic        is_branch;
    logic        mispredict;
    logic [21:0] data;
  } fu_wb_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] fu_valid,
  output logic [NUM_REQ-1:0] fu_ready,
  input  fu_wb_t             fu_pkt [NUM_REQ],
  input  logic [1:0]         global_epoch,
  input  logic               flush_valid,
  output logic               wb_valid,
  input  logic               wb_ready,
  output fu_wb_t             wb_pkt,
  output logic [REQ_W-1:0]   grant_idx
);
  logic               r_wb_valid;
  fu_wb_t             r_wb_pkt;
  logic [REQ_W-1:0]   r_grant_idx;
  logic [REQ_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] w_live;
  logic [NUM_REQ-1:0] w_stale;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_load_en;
  logic               w_found;
  logic [REQ_W-1:0]   w_gnt;
  int                 w_j;

  // classify requesters as live or stale against the current epoch
  always_comb begin
    w_live  = '0;
    w_stale = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_live[i]  = fu_valid[i] && (fu_pkt[i].epoch == global_epoch);
      w_stale[i] = fu_valid[i] && (fu_pkt[i].epoch != global_epoch);
    end
  end

`ifdef WB_ARB_BRANCH_PRIO_EN
  logic [NUM_REQ-1:0] w_br;
  // mispredicting branches pre-empt everything else when any are live
  always_comb begin
    w_br = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_br[i] = w_live[i] && fu_pkt[i].is_branch && fu_pkt[i].mispredict;
    w_cand = |w_br ? w_br : w_live;
  end
`else
  assign w_cand = w_live;
`endif

  // first candidate at or after the round-robin pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = int'(r_rr_ptr) + k;
      w_j = (w_j >= NUM_REQ) ? w_j - NUM_REQ : w_j;
      if (!w_found && w_cand[w_j]) begin
        w_found = 1'b1;
        w_gnt   = REQ_W'(w_j);
      end
    end
  end

  // a stale held packet frees the register just like a consume
  assign w_load_en = !r_wb_valid || wb_ready || (r_wb_pkt.epoch != global_epoch);
  assign w_onehot  = NUM_REQ'(1) << w_gnt;
  assign fu_ready  = (rst || flush_valid) ? '0 :
                     (w_stale | ((w_load_en && w_found) ? w_onehot : '0));

  // output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid  <= 1'b0;
      r_wb_pkt    <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else if (flush_valid) begin
      r_wb_valid <= 1'b0;
      r_rr_ptr   <= '0;
    end else if (w_load_en) begin
      r_wb_valid <= w_found;
      if (w_found) begin
        r_wb_pkt    <= fu_pkt[w_gnt];
        r_grant_idx <= w_gnt;
        r_rr_ptr    <= (w_gnt == REQ_W'(NUM_REQ - 1)) ? '0 : w_gnt + REQ_W'(1);
      end
    end
  end

  assign wb_valid  = r_wb_valid;
  assign wb_pkt    = r_wb_pkt;
  assign grant_idx = r_grant_idx;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic against a reference model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] fu_valid = '0;
  logic [N-1:0] fu_ready;
  fu_wb_t       fu_pkt [N];
  logic [1:0]   global_epoch = '0;
  logic         flush_valid = 1'b0;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  fu_wb_t       wb_pkt;
  logic [1:0]   grant_idx;

  int total = 0;
  int bad   = 0;

  bit           m_valid;
  fu_wb_t       m_pkt;
  int           m_gidx;
  int           m_ptr;
  logic [N-1:0] seen_ready;

  wb_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_pkt(fu_pkt),
    .global_epoch(global_epoch), .flush_valid(flush_valid), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_pkt(wb_pkt), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_pkt   = '0;
    m_gidx  = 0;
    m_ptr   = 0;
  endtask

  // one clock cycle: starts and ends at a falling edge with inputs already driven
  task automatic cycle();
    bit           live [N];
    bit           br_any;
    bit           le;
    int           g;
    logic [N-1:0] exp_rdy;
    br_any = 0;
    for (int i = 0; i < N; i++) begin
      live[i] = fu_valid[i] && fu_pkt[i].epoch == global_epoch;
`ifdef WB_ARB_BRANCH_PRIO_EN
      if (live[i] && fu_pkt[i].is_branch && fu_pkt[i].mispredict) br_any = 1;
`endif
    end
    le = !m_valid || wb_ready || m_pkt.epoch != global_epoch;
    g = -1;
    for (int off = 0; off < N; off++) begin
      int idx = (m_ptr + off) % N;
      bit ok = live[idx] && (!br_any || (fu_pkt[idx].is_branch && fu_pkt[idx].mispredict));
      if (g < 0 && ok) g = idx;
    end
    exp_rdy = '0;
    if (!flush_valid) begin
      for (int i = 0; i < N; i++)
        exp_rdy[i] = (fu_valid[i] && !live[i]) || (le && g == i);
    end
    #1;
    seen_ready = fu_ready;
    check("fu_ready", fu_ready, exp_rdy);
    @(posedge clk);
    if (flush_valid) begin
      m_valid = 0;
      m_ptr   = 0;
    end else if (le) begin
      m_valid = g >= 0;
      if (g >= 0) begin
        m_pkt  = fu_pkt[g];
        m_gidx = g;
        m_ptr  = (g + 1) % N;
      end
    end
    #1;
    check("wb_valid", wb_valid, m_valid);
    if (m_valid) begin
      check("wb_pkt", wb_pkt, m_pkt);
      check("grant_idx", grant_idx, m_gidx);
    end
    @(negedge clk);
  endtask

  task automatic set_pkts(input logic [1:0] ep);
    for (int i = 0; i < N; i++) begin
      fu_pkt[i] = '0;
      fu_pkt[i].rob_idx = 6'(i + 8);
      fu_pkt[i].epoch = ep;
      fu_pkt[i].data = 22'($urandom);
    end
  endtask

  task automatic randomize_inputs();
    if ($urandom_range(0, 7) == 0) global_epoch = 2'($urandom);
    for (int i = 0; i < N; i++) begin
      fu_pkt[i].rob_idx    = 6'($urandom);
      fu_pkt[i].epoch      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : global_epoch;
      fu_pkt[i].is_branch  = 1'($urandom);
      fu_pkt[i].mispredict = 1'($urandom);
      fu_pkt[i].data       = 22'($urandom);
    end
    fu_valid    = N'($urandom);
    wb_ready    = $urandom_range(0, 2) != 0;
    flush_valid = $urandom_range(0, 19) == 0;
  endtask

  initial begin
    int exp_g [5] = '{0, 1, 2, 3, 0};
    model_reset();
    set_pkts(2'd0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", wb_valid, 1'b0);
    check("reset_ready", fu_ready, '0);
    check("reset_grant", grant_idx, '0);
    @(negedge clk);
    rst = 1'b0;
    fu_valid = '1;
    wb_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("rr_seq", grant_idx, exp_g[c]);
    end
    fu_valid = 4'b0110;
    wb_ready = 1'b0;
    repeat (3) begin
      cycle();
      check("stall_ready", seen_ready, '0);
      check("stall_grant", grant_idx, 2'd0);
    end
    wb_ready = 1'b1;
    cycle();
    check("release_grant", grant_idx, 2'd1);
    fu_valid = '1;
    flush_valid = 1'b1;
    cycle();
    check("flush_ready", seen_ready, '0);
    check("flush_valid", wb_valid, 1'b0);
    flush_valid = 1'b0;
    cycle();
    check("post_flush_grant", grant_idx, 2'd0);
    global_epoch = 2'd2;
    fu_valid = 4'b0100;
    fu_pkt[2].epoch = 2'd1;
    cycle();
    check("stale_ready", seen_ready, 4'b0100);
    check("stale_no_wb", wb_valid, 1'b0);
    global_epoch = 2'd0;
    set_pkts(2'd0);
    fu_valid = 4'b0001;
    cycle();
    fu_valid = '0;
    wb_ready = 1'b0;
    global_epoch = 2'd1;
    cycle();
    check("held_stale_drop", wb_valid, 1'b0);
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        randomize_inputs();
        flush_valid = 1'b0;
        cycle();
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", wb_valid, 1'b0);
        check("async_rst_ready", fu_ready, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      randomize_inputs();
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
